// File: rtl/cache_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_pkg
// Shared definitions for the cache-to-memory arbiter and the caches around it.
//   GRANT_I / GRANT_D : encoding of which cache currently owns the memory port
//   LINE_WORDS        : words per cache line (burst length of a cached access)
//   OFFSET_WIDTH      : byte-offset bits inside one line
//   arb_state_e       : arbiter FSM state encoding
//   any_req()         : a 4-bit request/strobe vector counts as a request if
//                       any bit is set
// ---------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int LINE_WORDS   = 16;
  localparam int OFFSET_WIDTH = $clog2(LINE_WORDS) + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic logic any_req(input logic [3:0] req);
    return |req;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter, purely combinational.
//   req_icache  : instruction cache is requesting
//   req_dcache  : data cache is requesting
//   last_grant  : requester served most recently (GRANT_I / GRANT_D)
//   grant_valid : at least one requester is active
//   grant       : chosen requester (only meaningful when grant_valid)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import cache_mem_arbiter_pkg::*;
(
  input  logic req_icache,
  input  logic req_dcache,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // When both caches compete, the one not served last time wins.
  always_comb begin
    grant_valid = req_icache | req_dcache;
    grant       = GRANT_I;
    if (req_icache && req_dcache) begin
      grant = ~last_grant;
    end else if (req_dcache) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single burst-capable memory port (SRAM-AXI bridge side) between
// the instruction cache and the data cache. One cache is granted at a time;
// its address, direction, strobe and burst length are latched, the address
// phase and the beat phases are sequenced, and handshake responses are routed
// back to the granted cache only.
//
// Ports:
//   cache_clk, cache_rst         clock, asynchronous active-high reset
//   i_req/i_uncached/i_addr      icache request (active if any i_req bit set)
//   i_addr_ok/i_beat_ok/
//   i_data_ok/i_rdata            icache responses
//   d_req/d_wr/d_uncached/
//   d_addr/d_wdata               dcache request (d_req doubles as byte strobe)
//   d_addr_ok/d_beat_ok/
//   d_data_ok/d_rdata            dcache responses
//   mem_req/mem_wr/mem_strb/
//   mem_len/mem_addr/mem_wdata   memory-side request (mem_len = beats - 1)
//   mem_addr_ok/mem_beat_ok/
//   mem_data_ok/mem_rdata        memory-side responses
//   protocol_err                 sticky flag: burst length mismatch or a
//                                memory handshake in the wrong phase
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16
) (
  input  logic              cache_clk,
  input  logic              cache_rst,

  input  logic [3:0]        i_req,
  input  logic              i_uncached,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_beat_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,

  input  logic [3:0]        d_req,
  input  logic              d_wr,
  input  logic              d_uncached,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_beat_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_strb,
  output logic [3:0]        mem_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_beat_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              protocol_err
);

  import cache_mem_arbiter_pkg::*;

  localparam int LEN_W = 4;
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_LINE = LEN_W'(LINE_WORDS - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [3:0]        strb_q, strb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              protocol_err_q, protocol_err_d;

  logic              arb_valid;
  logic              arb_grant;
  logic              sel_uncached;
  logic [ADDR_W-1:0] sel_addr;
  logic [CNT_W-1:0]  beat_cnt_inc;
  logic [CNT_W-1:0]  beats_seen;
  logic [CNT_W-1:0]  beats_expected;

  rr_arbiter2 u_rr_arbiter2 (
    .req_icache  (any_req(i_req)),
    .req_dcache  (any_req(d_req)),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  assign sel_uncached = (arb_grant == GRANT_D) ? d_uncached : i_uncached;
  assign sel_addr     = (arb_grant == GRANT_D) ? d_addr : i_addr;

  // Saturating beat count; beats_seen includes a beat arriving this cycle so
  // the final beat is counted when it coincides with mem_data_ok.
  assign beat_cnt_inc   = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
  assign beats_seen     = mem_beat_ok ? beat_cnt_inc : beat_cnt_q;
  assign beats_expected = CNT_W'(len_q) + CNT_W'(1);

  always_ff @(posedge cache_clk or posedge cache_rst) begin
    if (cache_rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GRANT_I;
      grant_q        <= GRANT_I;
      wr_q           <= 1'b0;
      strb_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      wr_q           <= wr_d;
      strb_q         <= strb_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Next-state and output logic. Every response output is qualified by the
  // state and the latched grant, so the non-granted cache only ever sees 0.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    wr_d           = wr_q;
    strb_d         = strb_q;
    addr_d         = addr_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    protocol_err_d = protocol_err_q;

    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_strb  = '0;
    mem_len   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_addr_ok = 1'b0;
    i_beat_ok = 1'b0;
    i_data_ok = 1'b0;
    i_rdata   = '0;
    d_addr_ok = 1'b0;
    d_beat_ok = 1'b0;
    d_data_ok = 1'b0;
    d_rdata   = '0;

    // Handshakes arriving in the wrong phase are dropped but remembered.
    if (mem_addr_ok && (state_q != ST_ADDR)) begin
      protocol_err_d = 1'b1;
    end
    if ((mem_beat_ok || mem_data_ok) && (state_q != ST_DATA)) begin
      protocol_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          wr_d    = (arb_grant == GRANT_D) ? d_wr : 1'b0;
          strb_d  = (arb_grant == GRANT_D) ? d_req : 4'hF;
          len_d   = sel_uncached ? '0 : LEN_LINE;
          // Cached refills/writebacks always start at the line boundary.
          addr_d  = sel_uncached ? sel_addr : {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        mem_req  = 1'b1;
        mem_wr   = wr_q;
        mem_strb = strb_q;
        mem_len  = len_q;
        mem_addr = addr_q;
        if (mem_addr_ok) begin
          mem_req    = 1'b0;
          i_addr_ok  = (grant_q == GRANT_I);
          d_addr_ok  = (grant_q == GRANT_D);
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        mem_wr    = wr_q;
        mem_strb  = strb_q;
        mem_len   = len_q;
        mem_addr  = addr_q;
        mem_wdata = ((grant_q == GRANT_D) && wr_q) ? d_wdata : '0;
        if (mem_beat_ok) begin
          beat_cnt_d = beat_cnt_inc;
          if (grant_q == GRANT_I) begin
            i_beat_ok = 1'b1;
            i_rdata   = mem_rdata;
          end else begin
            d_beat_ok = 1'b1;
            d_rdata   = mem_rdata;
          end
        end
        if (mem_data_ok) begin
          i_data_ok    = (grant_q == GRANT_I);
          d_data_ok    = (grant_q == GRANT_D);
          if (beats_seen != beats_expected) begin
            protocol_err_d = 1'b1;
          end
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign protocol_err = protocol_err_q;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single burst-capable memory port (SRAM-AXI bridge side) between the instruction cache and the data cache.
- Grants one requester at a time and latches its address, direction and cached/uncached attribute.
- Sequences the address phase and the beat/data phases, then routes the handshake responses back to the granted cache only.
- Sits between inst_cache / data cache and the SRAM-AXI bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LINE_WORDS, 16, words per cache line, which is the burst length for cached transfers (64 B line).

Ports:
- cache_clk  in  1  clock.
- cache_rst  in  1  asynchronous reset, active-high.
- i_req  in  4  icache request; the request is active when the OR of all bits is 1.
- i_uncached  in  1  icache single-beat access.
- i_addr  in  ADDR_W  icache address.
- i_addr_ok  out  1  icache address accepted.
- i_beat_ok  out  1  icache beat valid.
- i_data_ok  out  1  icache last beat.
- i_rdata  out  DATA_W  icache read data.
- d_req  in  4  dcache request / byte strobe; the request is active when the OR of all bits is 1.
- d_wr  in  1  dcache write.
- d_uncached  in  1  dcache single-beat access.
- d_addr  in  ADDR_W  dcache address.
- d_wdata  in  DATA_W  dcache write data for the current beat.
- d_addr_ok  out  1  dcache address accepted.
- d_beat_ok  out  1  dcache beat done.
- d_data_ok  out  1  dcache last beat.
- d_rdata  out  DATA_W  dcache read data.
- mem_req  out  1  memory request.
- mem_wr  out  1  memory write.
- mem_strb  out  4  byte strobe.
- mem_len  out  4  number of beats minus 1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_addr_ok  in  1  memory address accepted.
- mem_beat_ok  in  1  memory beat done.
- mem_data_ok  in  1  memory last beat.
- mem_rdata  in  DATA_W  memory read data.
- protocol_err  out  1  sticky burst-length mismatch flag.

Behaviour:
- Reset (asynchronous):
  - state goes to IDLE; last_grant is set to I; beat_cnt and protocol_err are cleared.
  - All outputs go to 0, including mem_req and every *_ok signal.
- States: IDLE, ADDR, DATA.
- IDLE, arbitration:
  - If only one requester is active, grant it.
  - If both are active, grant the requester not equal to last_grant (round-robin).
  - On a grant:
    - latch grant, wr (d_wr for D, 0 for I), strb (d_req for D, 4'hF for I), addr and len;
    - len = 0 if uncached, otherwise LINE_WORDS-1;
    - for cached accesses, the latched addr is the line address (low log2(LINE_WORDS)+2 bits cleared);
    - go to ADDR.
  - Latency: a request seen in cycle N gives mem_req=1 in cycle N+1.
- ADDR:
  - mem_req=1; mem_wr, mem_strb, mem_len and mem_addr come from the latched registers.
  - On mem_addr_ok: pulse the granted *_addr_ok in the same cycle (combinational), set mem_req=0, clear beat_cnt, go to DATA.
- DATA:
  - mem_wdata = d_wdata when the grant is D and the access is a write, else 0.
  - On each mem_beat_ok: pulse the granted *_beat_ok, route mem_rdata to the granted *_rdata, and increment beat_cnt.
  - On mem_data_ok: pulse the granted *_data_ok.
    - If beat_cnt (including the current beat) != len+1, set protocol_err=1.
    - Set last_grant=grant and go to IDLE.
  - mem_data_ok must coincide with the final mem_beat_ok. A single-beat access asserts both in the same cycle.
- Back-to-back: the cycle after data_ok is spent in IDLE, so the earliest next mem_req is two cycles after data_ok.
- Non-granted requester: all of its *_ok outputs stay 0 and its rdata stays 0, even while the memory bus is active.
- Requester deasserts mid-transaction: ignored. The grant is held until mem_data_ok and the burst always completes.
- mem_addr_ok in IDLE or DATA, or mem_beat_ok/mem_data_ok outside DATA: ignored, and protocol_err is set.
- beat_cnt is log2(LINE_WORDS)+1 bits wide and saturates at its maximum.
- protocol_err clears only on reset.

Decomposition:
- Shared package: constants GRANT_I=1'b0 and GRANT_D=1'b1, the state encodings, and LINE_WORDS / OFFSET_WIDTH (shared with the caches).
- Sub-module: rr_arbiter2 (two requests plus last_grant gives one grant). It is small but separately testable.
- The FSM, latch registers and response routing stay in the top module.

Test Plan:
- Single icache miss at i_addr=0x8000_1234, cached:
  - mem_addr=0x8000_1200, mem_len=15, mem_wr=0, mem_req=1 one cycle after i_req;
  - 16 i_beat_ok pulses with the rdata passed through;
  - i_data_ok on beat 16; d_* outputs stay 0 throughout.
- Simultaneous i_req and d_req after reset (last_grant=I):
  - D is granted first, then I.
  - Repeated simultaneous requests alternate D, I, D, I.
- Uncached dcache write at d_addr=0xA000_0010, d_req=4'b0011, d_wdata=0x1234_5678:
  - mem_len=0, mem_strb=0011, mem_wdata=0x1234_5678;
  - d_addr_ok, then d_beat_ok and d_data_ok in the same cycle.
- Address stall: mem_addr_ok held low for 5 cycles.
  - mem_req stays 1 and the address is stable.
  - Changing i_addr during the stall does not change mem_addr.
- Reset asserted mid-burst after beat 7:
  - All outputs go to 0 immediately (asynchronously) and the state is IDLE.
  - After reset is released, a new request is granted normally.
- Cached burst where mem_data_ok arrives on beat 8:
  - protocol_err=1 and stays set.
  - The FSM returns to IDLE and serves the next request.
